// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-source result FIFOs (ALU, load/store) feeding one
// registered broadcast bus. The sources take turns round-robin when both are pending.

module cdb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; occupancy lives in count, so
    // stale slots are never observed and the array can map to plain RAM.
    always_ff @(posedge clk_in) begin
        if (push) mem[wptr] <= wdata;
    end

    assign head = mem[rptr];
endmodule

module cdb_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rob_clear,
    input  logic        alu_done,
    input  logic [31:0] alu_res,
    input  logic        alu_jump,
    input  logic [31:0] alu_jump_addr,
    input  logic [4:0]  alu_rob_pos,
    output logic        alu_ready,
    input  logic        load_done,
    input  logic [31:0] load_res,
    input  logic [4:0]  load_rob_pos,
    output logic        load_ready,
    output logic        cdb_valid,
    output logic [4:0]  cdb_rob_pos,
    output logic [31:0] cdb_val,
    output logic        cdb_jump,
    output logic [31:0] cdb_jump_addr
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [31:0] res;
        logic        jump;
        logic [31:0] jump_addr;
        logic [4:0]  rob_pos;
    } alu_entry_t;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rob_pos;
    } load_entry_t;

    alu_entry_t  alu_in;
    alu_entry_t  alu_head;
    load_entry_t load_in;
    load_entry_t load_head;

    logic [CW-1:0] alu_count;
    logic [CW-1:0] load_count;
    logic          alu_push;
    logic          alu_pop;
    logic          load_push;
    logic          load_pop;
    logic          flush;
    logic          grant_alu;
    logic          grant_load;
    logic          rr;

    assign alu_in  = '{res: alu_res, jump: alu_jump, jump_addr: alu_jump_addr, rob_pos: alu_rob_pos};
    assign load_in = '{res: load_res, rob_pos: load_rob_pos};

    // Readiness comes from pre-pop occupancy, so a full FIFO refuses a push even while popping.
    assign alu_ready  = rdy_in && (alu_count < CW'(DEPTH));
    assign load_ready = rdy_in && (load_count < CW'(DEPTH));

    assign flush     = rdy_in && rob_clear;
    assign alu_push  = alu_ready && !rob_clear && alu_done;
    assign load_push = load_ready && !rob_clear && load_done;
    assign alu_pop   = rdy_in && !rob_clear && grant_alu;
    assign load_pop  = rdy_in && !rob_clear && grant_load;

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        grant_alu  = 1'b0;
        grant_load = 1'b0;
        if (alu_count != '0 && load_count != '0) begin
            grant_alu  = !rr;
            grant_load = rr;
        end else if (alu_count != '0) begin
            grant_alu  = 1'b1;
        end else if (load_count != '0) begin
            grant_load = 1'b1;
        end
    end

    cdb_fifo #(.DEPTH(DEPTH), .WIDTH($bits(alu_entry_t))) u_alu_fifo (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .clear  (flush),
        .push   (alu_push),
        .pop    (alu_pop),
        .wdata  (alu_in),
        .head   (alu_head),
        .count  (alu_count)
    );

    cdb_fifo #(.DEPTH(DEPTH), .WIDTH($bits(load_entry_t))) u_load_fifo (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .clear  (flush),
        .push   (load_push),
        .pop    (load_pop),
        .wdata  (load_in),
        .head   (load_head),
        .count  (load_count)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rr            <= 1'b0;
            cdb_valid     <= 1'b0;
            cdb_rob_pos   <= '0;
            cdb_val       <= '0;
            cdb_jump      <= 1'b0;
            cdb_jump_addr <= '0;
        end else if (flush) begin
            rr        <= 1'b0;
            cdb_valid <= 1'b0;
        end else if (rdy_in) begin
            if (grant_alu) begin
                rr            <= 1'b1;
                cdb_valid     <= 1'b1;
                cdb_rob_pos   <= alu_head.rob_pos;
                cdb_val       <= alu_head.res;
                cdb_jump      <= alu_head.jump;
                cdb_jump_addr <= alu_head.jump_addr;
            end else if (grant_load) begin
                rr            <= 1'b0;
                cdb_valid     <= 1'b1;
                cdb_rob_pos   <= load_head.rob_pos;
                cdb_val       <= load_head.res;
                cdb_jump      <= 1'b0;
                cdb_jump_addr <= '0;
            end else begin
                cdb_valid     <= 1'b0;
            end
        end
    end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common-data-bus arbiter for the out-of-order core. It buffers completed results from the ALU and the load/store buffer in per-source FIFOs and grants exactly one result per cycle onto a single registered broadcast bus. That bus feeds the reorder buffer, the reservation station and the load/store buffer, which are the only consumers. Grants alternate round-robin between sources when both have pending results, and a misprediction clear empties everything.

## Interface
- DEPTH, 4, entries per source FIFO; power of two, ≥2
- clk_in  input  1  core clock
- rst_in  input  1  synchronous reset, active-high
- rdy_in  input  1  global enable; low freezes all state
- rob_clear  input  1  flush, asserted after a mispredicted branch commits
- alu_done  input  1  ALU result valid
- alu_res  input  32  ALU result value
- alu_jump  input  1  branch/jump taken
- alu_jump_addr  input  32  branch/jump target
- alu_rob_pos  input  5  destination RoB index
- alu_ready  output  1  ALU FIFO can accept; combinational: rdy_in && alu_count < DEPTH
- load_done  input  1  load result valid
- load_res  input  32  loaded value
- load_rob_pos  input  5  destination RoB index
- load_ready  output  1  load FIFO can accept; combinational: rdy_in && load_count < DEPTH
- cdb_valid  output  1  broadcast valid (registered)
- cdb_rob_pos  output  5  broadcast RoB index
- cdb_val  output  32  broadcast value
- cdb_jump  output  1  taken flag; always 0 for load results
- cdb_jump_addr  output  32  target; always 0 for load results

## Operation
- Two FIFOs, each holding DEPTH entries. An ALU entry is {res, jump, jump_addr, rob_pos}; a load entry is {res, rob_pos}. Each FIFO has read and write pointers of width log2(DEPTH) that wrap modulo DEPTH, plus a count of width log2(DEPTH)+1.
- Push: at an edge where rdy_in=1, rob_clear=0, X_done=1 and X_ready=1, the entry is written at wptr and wptr advances. If X_done=1 while X_ready=0, the result is dropped. This is illegal for producers, and the bench flags it.
- Full FIFO: ready is derived from the count before any pop. A full FIFO therefore refuses a push even in a cycle where it pops.
- Arbitration state is a 1-bit rr register; rr=0 prefers the ALU.
- Grant selection is evaluated on the registered FIFO state each enabled cycle:
  - Both FIFOs non-empty: grant the ALU if rr=0, otherwise grant the load FIFO.
  - Exactly one FIFO non-empty: grant that FIFO.
  - Both empty: no grant.
- On a grant: pop the head of the granted FIFO, load the cdb_* registers from it, and set cdb_valid=1. Set rr=1 after an ALU grant and rr=0 after a load grant.
- No grant: cdb_valid<=0; the other cdb_* registers hold their values.
- Simultaneous push and pop on the same FIFO: the count is unchanged and both pointers advance.
- rob_clear=1 with rdy_in=1:
  - Both FIFOs are emptied (pointers and counts set to 0), rr<=0 and cdb_valid<=0.
  - Any push in that cycle is discarded.
  - rob_clear takes priority over push and over grant.
- rdy_in=0: no push, no pop, all registers hold, and cdb_valid holds. Consumers are gated by rdy_in as well.
- rst_in takes precedence over everything else and acts regardless of rdy_in. It sets pointers, counts and rr to 0, and sets cdb_valid, cdb_rob_pos, cdb_val, cdb_jump and cdb_jump_addr to 0. Reset during traffic loses all buffered results.

## Timing
- Latency:
  - Uncontended: a result presented before edge k is written at edge k and broadcast after edge k+1. cdb_valid is high during the cycle following edge k+1.
  - Contended: each loss adds one cycle.
- Throughput is one broadcast per cycle in aggregate. When both FIFOs stay non-empty, grants alternate strictly between them.
- cdb_valid is a one-cycle pulse per result. Back-to-back grants keep it high on consecutive cycles.
- The ready outputs are the only combinational outputs.

## Test plan
- Reset:
  - Stimulus: assert rst_in for 2 cycles.
  - Required: all cdb_* = 0, alu_ready=1 and load_ready=1 with rdy_in=1.
- Single ALU result:
  - Stimulus: push res=0x1234, jump=1, addr=0x80, pos=3 at edge 0.
  - Required: after edge 1, cdb_valid=1, pos=3, val=0x1234, jump=1, addr=0x80. After edge 2, cdb_valid=0.
- Round-robin:
  - Stimulus: from reset, push ALU pos=1 and load pos=2 at the same edge, then idle.
  - Required: broadcasts are pos=1 (jump=0 per input) then pos=2 (jump=0, addr=0) on consecutive cycles.
  - Stimulus: then push ALU pos=5 and load pos=6 together.
  - Required: broadcasts are pos=5 then pos=6, since rr=0 after the load grant.
- Backpressure:
  - Stimulus: with load FIFO holding 1 entry, issue 5 consecutive ALU pushes, one per cycle, while alu_ready stays high.
  - Required: ALU is granted 1 entry, then the load entry, then ALU entries. alu_ready goes low only if the count reaches 4, and no result is lost or duplicated. The scoreboard checks the order.
- Flush:
  - Stimulus: fill the ALU FIFO with 3 entries and the load FIFO with 2, then assert rob_clear for one edge together with an ALU push.
  - Required: the next cycle has cdb_valid=0, both readies are 1, and there are no further broadcasts.
- Stall:
  - Stimulus: drop rdy_in for 3 cycles while cdb_valid=1 and entries are pending.
  - Required: cdb outputs and valid hold, and alu_ready=0 and load_ready=0. After rdy_in rises, broadcasting resumes in the original order.
